// File: rtl/ps2_traffic_logger.sv
// ps2_traffic_logger
// Captures PS/2 host-to-device and device-to-host bytes into an event FIFO
// (up to two writes per cycle) and streams each event to a UART transmitter
// as one ASCII line: "H 1A\r\n" for host bytes, "D FA\r\n" for device bytes.
// Optional feature macro PS2_LOG_TS_EN: a free-running TS_W-bit cycle counter
// is stored with every entry and each line gains " @" plus TS_W/4 hex digits.
// Events arriving while the FIFO is full are counted in a saturating counter.
module ps2_traffic_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_stb_i,
    input  logic [7:0]             host_data_i,
    input  logic                   dev_stb_i,
    input  logic [7:0]             dev_data_i,
    input  logic                   uart_ready_i,
    output logic                   uart_wr_en_o,
    output logic [7:0]             uart_wr_data_o,
    output logic [7:0]             drop_cnt_o,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic                   busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef PS2_LOG_TS_EN
    localparam int ENT_W  = 9 + TS_W;
    localparam int LINE_L = 8 + TS_W / 4;
`else
    localparam int ENT_W  = 9;
    localparam int LINE_L = 6;
`endif
    localparam int IDX_W = $clog2(LINE_L);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Entry layout: {dir, byte[7:0]} with the timestamp in the low bits when enabled.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_q, drop_d;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [ENT_W-1:0] line_q;
    logic             wr_en_q;
    logic [7:0]       wr_data_q;

    logic [ENT_W-1:0] host_ent, dev_ent;
    logic             pop, host_acc, dev_acc;
    logic [CNT_W-1:0] free_slots;
    logic [1:0]       n_push, n_drop;
    logic [8:0]       drop_sum;
    logic             line_dir;
    logic [7:0]       line_byte;
    logic [7:0]       cur_char;

`ifdef PS2_LOG_TS_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] line_ts;
    logic [TS_W-1:0] ts_shift;

    // Free-running cycle counter; both entries captured on one edge share its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            // NOTE: registered state is always updated with non-blocking assignments so every flop samples pre-edge values.
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign host_ent = {1'b0, host_data_i, ts_q};
    assign dev_ent  = {1'b1, dev_data_i, ts_q};
    assign line_ts  = line_q[TS_W-1:0];
`else
    assign host_ent = {1'b0, host_data_i};
    assign dev_ent  = {1'b1, dev_data_i};
`endif

    assign line_dir  = line_q[ENT_W-1];
    assign line_byte = line_q[ENT_W-2 -: 8];

    // The formatter takes the head whenever it is idle and something is queued.
    assign pop = (state_q == IDLE) && (count_q != '0);

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Admission: a same-cycle pop frees its slot; the host entry has priority over the device entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        host_acc   = host_stb_i && (free_slots != '0);
        dev_acc    = dev_stb_i && (free_slots > CNT_W'(host_acc));
        n_push     = {1'b0, host_acc} + {1'b0, dev_acc};
        n_drop     = {1'b0, host_stb_i & ~host_acc} + {1'b0, dev_stb_i & ~dev_acc};
        drop_sum   = {1'b0, drop_q} + {7'b0, n_drop};
        drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(n_push) - CNT_W'(pop);
    end

    // FIFO pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage: host entry lands at the write pointer, a simultaneous device entry right after it.
    // NOTE: the storage array has no reset; pointers and count define validity, and resetting RAM would block inference.
    always_ff @(posedge clk) begin
        if (host_acc) begin
            mem_q[wr_ptr_q] <= host_ent;
        end else if (dev_acc) begin
            mem_q[wr_ptr_q] <= dev_ent;
        end
        if (host_acc && dev_acc) begin
            mem_q[wr_ptr_q + PTR_W'(1)] <= dev_ent;
        end
    end

    // Character at the current line index.
    always_comb begin
        cur_char = 8'h0A;
`ifdef PS2_LOG_TS_EN
        ts_shift = line_ts >> (4 * (LINE_L - 3 - int'(idx_q)));
`endif
        if (idx_q == IDX_W'(0)) begin
            cur_char = line_dir ? 8'h44 : 8'h48;
        end else if (idx_q == IDX_W'(1)) begin
            cur_char = 8'h20;
        end else if (idx_q == IDX_W'(2)) begin
            cur_char = hex_char(line_byte[7:4]);
        end else if (idx_q == IDX_W'(3)) begin
            cur_char = hex_char(line_byte[3:0]);
`ifdef PS2_LOG_TS_EN
        end else if (idx_q == IDX_W'(4)) begin
            cur_char = 8'h20;
        end else if (idx_q == IDX_W'(5)) begin
            cur_char = 8'h40;
        end else if (idx_q < IDX_W'(LINE_L - 2)) begin
            cur_char = hex_char(ts_shift[3:0]);
`endif
        end else if (idx_q == IDX_W'(LINE_L - 2)) begin
            cur_char = 8'h0D;
        end
    end

    // Line formatter: load a line in IDLE, emit one character per ready cycle in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            line_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'h00;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        line_q  <= mem_q[rd_ptr_q];
                        idx_q   <= '0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (uart_ready_i) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= cur_char;
                        if (idx_q == IDX_W'(LINE_L - 1)) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_wr_en_o   = wr_en_q;
    assign uart_wr_data_o = wr_data_q;
    assign drop_cnt_o     = drop_q;
    assign fifo_level_o   = count_q;
    assign busy_o         = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_ps2_traffic_logger.sv
// Testbench for ps2_traffic_logger: scoreboard of expected UART characters
// filled when strobes are driven and drained by a negedge monitor, a table of
// single-event vectors, and hand-written sequences for overflow, saturation,
// ready throttling, mid-line reset and (with PS2_LOG_TS_EN) timestamps.
`timescale 1ns/1ps
module tb_ps2_traffic_logger;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
`ifdef PS2_LOG_TS_EN
    localparam int LINE_L = 8 + TS_W / 4;
`else
    localparam int LINE_L = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_stb_i = 1'b0;
    logic [7:0] host_data_i = 8'h00;
    logic       dev_stb_i = 1'b0;
    logic [7:0] dev_data_i = 8'h00;
    logic       uart_ready_i = 1'b1;
    logic       uart_wr_en_o;
    logic [7:0] uart_wr_data_o;
    logic [7:0] drop_cnt_o;
    logic [3:0] fifo_level_o;
    logic       busy_o;

    ps2_traffic_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_stb_i     (host_stb_i),
        .host_data_i    (host_data_i),
        .dev_stb_i      (dev_stb_i),
        .dev_data_i     (dev_data_i),
        .uart_ready_i   (uart_ready_i),
        .uart_wr_en_o   (uart_wr_en_o),
        .uart_wr_data_o (uart_wr_data_o),
        .drop_cnt_o     (drop_cnt_o),
        .fifo_level_o   (fifo_level_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         wr_count = 0;
    logic [7:0] sb[$];

`ifdef PS2_LOG_TS_EN
    logic [TS_W-1:0] tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + TS_W'(1);
    end
`endif

    typedef struct {
        logic       hs;
        logic [7:0] hd;
        logic       ds;
        logic [7:0] dd;
        int         exp_lines;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[int'(n)];
    endfunction

    task automatic push_line(input logic dir, input logic [7:0] b);
        sb.push_back(dir ? 8'h44 : 8'h48);
        sb.push_back(8'h20);
        sb.push_back(hex_ch(b[7:4]));
        sb.push_back(hex_ch(b[3:0]));
`ifdef PS2_LOG_TS_EN
        sb.push_back(8'h20);
        sb.push_back(8'h40);
        for (int k = TS_W / 4 - 1; k >= 0; k--) sb.push_back(hex_ch(4'(tb_cnt >> (4 * k))));
`endif
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    task automatic push_const(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One-cycle strobes; expected lines are queued for the events the bench knows will be accepted.
    task automatic drive(input logic hs, input logic [7:0] hd, input logic ds, input logic [7:0] dd,
                         input logic exp_h, input logic exp_d);
        host_stb_i  = hs;
        host_data_i = hd;
        dev_stb_i   = ds;
        dev_data_i  = dd;
        if (exp_h) push_line(1'b0, hd);
        if (exp_d) push_line(1'b1, dd);
        step();
        host_stb_i = 1'b0;
        dev_stb_i  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy_o; i++) step();
        check("drain_done", busy_o, 1'b0);
    endtask

    // Character monitor: every write must follow a ready edge and match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && uart_wr_en_o) begin
            wr_count++;
            check("ready_at_write", uart_ready_i, 1'b1);
            if (sb.size() == 0) begin
                check("extra_char_en", uart_wr_en_o, 1'b0);
            end else begin
                check("char", uart_wr_data_o, sb.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  t1_exp[6];
        logic [31:0] pat, exp_pat;
        logic        found;
        int          w0;

        t1_exp = '{8'h48, 8'h20, 8'h31, 8'h41, 8'h0D, 8'h0A};
        vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 1, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1, 8'h00};
        vecs[2] = '{1'b1, 8'h09, 1'b0, 8'h00, 1, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h0A, 1, 8'h00};
        vecs[4] = '{1'b1, 8'h9F, 1'b1, 8'hA0, 2, 8'h00};
        vecs[5] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h00};
        vecs[7] = '{1'b1, 8'hFF, 1'b1, 8'h00, 2, 8'h00};

        // Reset state
        repeat (2) step();
        check("rst_wr_en", uart_wr_en_o, 1'b0);
        check("rst_wr_data", uart_wr_data_o, 8'h00);
        check("rst_drop", drop_cnt_o, 8'h00);
        check("rst_level", fifo_level_o, 4'd0);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        step();

        // Single host byte: latency and exact characters
        drive(1'b1, 8'h1A, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_level", fifo_level_o, 4'd1);
        check("t1_busy", busy_o, 1'b1);
        step();
        check("t1_popped_level", fifo_level_o, 4'd0);
        check("t1_no_early_wr", uart_wr_en_o, 1'b0);
        for (int i = 0; i < LINE_L; i++) begin
            step();
            check("t1_wr_en", uart_wr_en_o, 1'b1);
            if (i < 4) check("t1_char", uart_wr_data_o, t1_exp[i]);
            else if (i >= LINE_L - 2) check("t1_char", uart_wr_data_o, t1_exp[i - LINE_L + 6]);
        end
        step();
        check("t1_wr_en_after", uart_wr_en_o, 1'b0);
        check("t1_data_held", uart_wr_data_o, 8'h0A);
        check("t1_busy_after", busy_o, 1'b0);

        // Simultaneous host and device: host line first, one idle cycle between lines
        drive(1'b1, 8'hF4, 1'b1, 8'hFA, 1'b1, 1'b1);
        check("t2_level", fifo_level_o, 4'd2);
        pat = '0;
        exp_pat = '0;
        for (int k = 0; k < 2 * LINE_L + 3; k++) begin
            if (k > 0) step();
            pat[k] = uart_wr_en_o;
            exp_pat[k] = (k >= 2 && k < 2 + LINE_L) || (k >= 3 + LINE_L && k < 3 + 2 * LINE_L);
        end
        check("t2_wr_pattern", pat, exp_pat);
        check("t2_drop", drop_cnt_o, 8'h00);
        wait_idle(20);

        // Table of single-cycle events
        for (int i = 0; i < 8; i++) begin
            w0 = wr_count;
            drive(vecs[i].hs, vecs[i].hd, vecs[i].ds, vecs[i].dd, vecs[i].hs, vecs[i].ds);
            wait_idle(60);
            check("vec_writes", wr_count - w0, vecs[i].exp_lines * LINE_L);
            check("vec_drop", drop_cnt_o, vecs[i].exp_drop);
        end

        // Overflow: one line held in the formatter, then 10 strobes into 8 slots
        uart_ready_i = 1'b0;
        drive(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("t4_level_held", fifo_level_o, 4'd0);
        check("t4_busy_held", busy_o, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00, i < 8, 1'b0);
        check("t4_level_full", fifo_level_o, 4'd8);
        check("t4_drop2", drop_cnt_o, 8'd2);

        // Full FIFO: a push on the pop edge takes the freed slot
        uart_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (uart_wr_en_o && uart_wr_data_o == 8'h0A) found = 1'b1;
        end
        check("t4_line_end_seen", found, 1'b1);
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_push_on_pop_level", fifo_level_o, 4'd8);
        check("t4_push_on_pop_drop", drop_cnt_o, 8'd2);
        wait_idle(200);

        // Free space 1 with both strobes: host kept, device dropped; then saturation
        uart_ready_i = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h10 + 8'(i), 1'b1, 8'h20 + 8'(i), 1'b1, 1'b1);
        drive(1'b1, 8'h13, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h14, 1'b1, 8'h24, 1'b1, 1'b0);
        check("t5_level", fifo_level_o, 4'd8);
        check("t5_drop3", drop_cnt_o, 8'd3);
        for (int i = 0; i < 100; i++) drive(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b0, 1'b0);
        check("t5_drop_203", drop_cnt_o, 8'd203);
        for (int i = 0; i < 50; i++) drive(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b0, 1'b0);
        check("t5_drop_sat", drop_cnt_o, 8'hFF);
        check("t5_level_sat", fifo_level_o, 4'd8);
        uart_ready_i = 1'b1;
        wait_idle(300);

        // Ready toggling every cycle: each character exactly once and in order
        w0 = wr_count;
        drive(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            uart_ready_i = ~uart_ready_i;
            step();
        end
        uart_ready_i = 1'b1;
        wait_idle(50);
        check("t6_toggle_writes", wr_count - w0, LINE_L);

        // Reset after the third character with three entries queued
        uart_ready_i = 1'b0;
        drive(1'b1, 8'h61, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h62 + 8'(i), 1'b0, 8'h00, 1'b1, 1'b0);
        check("t7_level3", fifo_level_o, 4'd3);
        uart_ready_i = 1'b1;
        w0 = wr_count;
        for (int i = 0; i < 20 && (wr_count - w0) < 3; i++) step();
        check("t7_three_chars", wr_count - w0, 3);
        rst_n = 1'b0;
        #1;
        check("t7_rst_wr_en", uart_wr_en_o, 1'b0);
        check("t7_rst_wr_data", uart_wr_data_o, 8'h00);
        check("t7_rst_drop", drop_cnt_o, 8'h00);
        check("t7_rst_level", fifo_level_o, 4'd0);
        check("t7_rst_busy", busy_o, 1'b0);
        sb.delete();
        step();
        rst_n = 1'b1;
        w0 = wr_count;
        repeat (20) step();
        check("t7_silent_after_reset", wr_count - w0, 0);
        check("t7_idle_after_reset", busy_o, 1'b0);
        w0 = wr_count;
        drive(1'b1, 8'h9E, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_idle(50);
        check("t7_new_line", wr_count - w0, LINE_L);

`ifdef PS2_LOG_TS_EN
        // Timestamps: stamp at FFFF, then the next event carries the wrapped count
        for (int i = 0; i < 70000 && tb_cnt != 16'hFFFF; i++) step();
        check("ts_reach_ffff", tb_cnt, 16'hFFFF);
        push_const("H 11 @FFFF");
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 400 && tb_cnt != 16'h00C3; i++) step();
        check("ts_reach_00c3", tb_cnt, 16'h00C3);
        w0 = wr_count;
        push_const("D AA @00C3");
        drive(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0);
        wait_idle(50);
        check("ts_line_len", wr_count - w0, 12);
`endif

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_traffic_logger.md
# ps2_traffic_logger

Parametrised PS/2 traffic logger between the PS/2 host controller and the UART transmitter. It captures host-to-device and device-to-host bytes into an event FIFO, so bursts and simultaneous events are never serialised at the source. Each event is formatted as one ASCII line, "H 1A\r\n" or "D FA\r\n", with an optional cycle timestamp. Characters are streamed to the UART under a ready handshake; events lost to overflow are counted.

## Interface
- DEPTH, 8: event FIFO entries; power of two, ≥2.
- TS_W, 16: timestamp width in bits; multiple of 4, 4..32. Used only with PS2_LOG_TS_EN.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- host_stb  in  1  one-cycle strobe: byte written by host to PS/2 controller.
- host_data  in  8  byte qualified by host_stb.
- dev_stb  in  1  one-cycle strobe: byte received from device.
- dev_data  in  8  byte qualified by dev_stb.
- uart_ready  in  1  UART TX can accept a character this cycle.
- uart_wr_en  out  1  registered character write strobe.
- uart_wr_data  out  8  registered ASCII character.
- drop_cnt  out  8  events dropped on FIFO full; saturating.
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued.
- busy  out  1  high when the FIFO is non-empty or a line is in progress.

## Operation
- Reset values: uart_wr_en=0, uart_wr_data=8'h00, drop_cnt=0, fifo_level=0, busy=0; FIFO pointers 0; formatter in IDLE; timestamp counter 0.
- Capture: an entry is {dir, byte[7:0]} plus, when enabled, ts[TS_W-1:0]. dir is 0 for host and 1 for device.
- Capture allows up to two writes per cycle. On a simultaneous host_stb and dev_stb, the host entry is written first and the device entry second.
- Free space 1 with both strobes: the host entry is kept, the device entry is dropped, drop_cnt +1.
- Free space 0: every strobed event is dropped. drop_cnt increments by 1 or 2 and saturates at 8'hFF with no wrap.
- A pop in the same cycle as a push frees its slot for that cycle's pushes, so a full FIFO accepts 1 write per pop.
- Formatter FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the line register and go to EMIT with char index 0.
  - EMIT: when uart_ready=1, register char[idx] onto uart_wr_data, pulse uart_wr_en, idx+1. When uart_ready=0, hold idx and drive uart_wr_en=0.
  - After the last character, return to IDLE.
- Line characters, in order:
  - 'H' (8'h48) or 'D' (8'h44);
  - space (8'h20);
  - high nibble, then low nibble, as upper-case hex (0-9 → 8'h30-39, A-F → 8'h41-46);
  - with PS2_LOG_TS_EN only: space, '@' (8'h40), then TS_W/4 hex digits, MS nibble first;
  - CR (8'h0D), LF (8'h0A).
- Line length L is 6, or 8+TS_W/4 with the timestamp.
- uart_wr_data keeps its last value while uart_wr_en=0.
- busy = (fifo_level≠0) | (state≠IDLE).
- Asynchronous reset mid-line abandons the line and flushes the FIFO. No partial resumption.

## Timing
- Strobe sampled at edge N; fifo_level reflects the entry after edge N.
- Empty FIFO and IDLE formatter:
  - pop at edge N+1;
  - first uart_wr_en high in the cycle after edge N+2, i.e. 2-cycle latency from strobe to the first registered character.
- With uart_ready held high, the L characters come out on consecutive cycles.
- Between lines, the FSM spends one cycle in IDLE, so consecutive lines are separated by exactly 1 idle cycle.
- uart_ready is sampled in the same cycle the character is registered. A character is never emitted unless uart_ready was 1 at that edge.

## Configuration
- PS2_LOG_TS_EN defined:
  - a free-running TS_W-bit cycle counter runs from reset, wrapping 2^TS_W-1→0;
  - each entry stores the counter value at its capture edge, identical for simultaneous host and device entries;
  - lines carry " @" plus TS_W/4 hex digits.
- PS2_LOG_TS_EN undefined: no counter and no timestamp FIFO storage; lines are 6 characters. TS_W is ignored.

## Test plan
- Single host byte 8'h1A, uart_ready=1, macro off → 6 consecutive writes "H 1A\r\n" (48 20 31 41 0D 0A), first write 2 cycles after the strobe.
- Simultaneous host 8'hF4 and dev 8'hFA, empty FIFO → "H F4\r\n" then "D FA\r\n" with a 1-cycle gap; drop_cnt=0.
- uart_ready=0, 10 host strobes with DEPTH=8 → fifo_level=8, drop_cnt=2. Releasing ready drains 8 lines in order; a further 300 drops saturate drop_cnt at 8'hFF.
- uart_ready toggling 1/0 every cycle during a line → each character appears exactly once and in order; idx is held while ready=0.
- Macro on, TS_W=16, dev byte 8'hAA captured at counter 16'h00C3 → "D AA @00C3\r\n" (12 chars). Strobe at counter 16'hFFFF → stamp reads "FFFF"; the next event is stamped from the wrapped count.
- rst_n asserted after the 3rd character of a line with 3 entries queued → all outputs immediately reset values. After release, no characters until a new strobe.
